// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI memory-side blocks: access-size encoding and the latched dmem request.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    DSZ_BYTE = 2'b00,
    DSZ_HALF = 2'b01,
    DSZ_WORD = 2'b10,
    DSZ_RSVD = 2'b11
  } dmem_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    dmem_size_e  size;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } dmem_req_t;

  // Inclusive range test; an empty range (lo > hi) never matches.
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/arm7tdmi_dmem_ram.sv
// Word RAM with per-byte-lane write enables and a registered read port (one-cycle read latency).
// Read register only updates on re, so it holds the last loaded word; it clears on reset, the array does not.
module arm7tdmi_dmem_ram #(
  parameter int WORD_AW   = 12,
  parameter     INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_AW-1:0] addr,
  input  logic [3:0]         we,
  input  logic [31:0]        wdata,
  input  logic               re,
  output logic [31:0]        rdata
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (we[n]) mem[addr][8*n +: 8] <= wdata[8*n +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/arm7tdmi_dmem_responder.sv
// Data-memory target for the core's dmem port: banked byte-writable RAM, optional wait states, abort decode.
// Ready pulses WAIT_STATES+1 cycles after acceptance; the initiator holds the request, nothing is buffered.
module arm7tdmi_dmem_responder
  import arm7tdmi_pkg::*;
#(
  parameter int          WORD_AW     = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          ALIGN_ABORT = 1,
  parameter logic [31:0] WP_BASE     = 32'hFFFF_FFFF,
  parameter logic [31:0] WP_LIMIT    = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_vaddr,
  input  logic        dmem_req,
  input  logic        dmem_write,
  input  logic [1:0]  dmem_size,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_en,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_abort
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  dmem_req_t    req_q, req_in, req_eff;
  logic         accept, enter_resp;
  logic [31:0]  off;
  logic         range_err, size_err, align_err, wp_err, abort;
  logic [3:0]   ram_we;
  logic         ram_re;

  assign req_in = '{addr:    dmem_vaddr,
                    write:   dmem_write,
                    size:    dmem_size_e'(dmem_size),
                    wdata:   dmem_wdata,
                    byte_en: dmem_byte_en};

  assign accept = (state_q == ST_IDLE) && dmem_req;

  // With no wait states the commit happens on the acceptance edge itself, so use the live request there.
  assign req_eff = (state_q == ST_IDLE) ? req_in : req_q;

  always_comb begin
    off       = req_eff.addr - BASE_ADDR;
    range_err = (off >> (WORD_AW + 2)) != 32'd0;
    size_err  = (req_eff.size == DSZ_RSVD);
    align_err = (ALIGN_ABORT != 0) &&
                (((req_eff.size == DSZ_WORD) && (req_eff.addr[1:0] != 2'b00)) ||
                 ((req_eff.size == DSZ_HALF) && req_eff.addr[0]));
    wp_err    = 1'b0;
    if (req_eff.write) begin
      for (int n = 0; n < 4; n++) begin
        if (req_eff.byte_en[n] && in_range({req_eff.addr[31:2], 2'(n)}, WP_BASE, WP_LIMIT))
          wp_err = 1'b1;
      end
    end
    abort = range_err || size_err || align_err || wp_err;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req) begin
          if (WS != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      dmem_ready <= 1'b0;
      dmem_abort <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dmem_ready <= enter_resp;
      dmem_abort <= enter_resp && abort;
      if (accept) req_q <= req_in;
    end
  end

  // Low address bits never reach the index, which gives the forced alignment when ALIGN_ABORT=0.
  // rst_n gating keeps a held-in-reset request from touching the array.
  assign ram_we = (enter_resp && rst_n && req_eff.write && !abort) ? req_eff.byte_en : 4'b0000;
  assign ram_re = enter_resp && rst_n && !req_eff.write && !abort;

  arm7tdmi_dmem_ram #(
    .WORD_AW   (WORD_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (off[WORD_AW+1:2]),
    .we    (ram_we),
    .wdata (req_eff.wdata),
    .re    (ram_re),
    .rdata (dmem_rdata)
  );

endmodule

// File: tb/tb_arm7tdmi_dmem_responder.sv
// Directed bench: instance a has no wait states, instance b has three; both write-protect 0x3000-0x30FF.
module tb_arm7tdmi_dmem_responder;
  import arm7tdmi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] a_vaddr, a_wdata, a_rdata, b_vaddr, b_wdata, b_rdata;
  logic        a_req, a_write, a_ready, a_abort, b_req, b_write, b_ready, b_abort;
  logic [1:0]  a_size, b_size;
  logic [3:0]  a_be, b_be;

  arm7tdmi_dmem_responder #(
    .WORD_AW(12), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ALIGN_ABORT(1),
    .WP_BASE(32'h3000), .WP_LIMIT(32'h30FF), .INIT_FILE("")
  ) u_ws0 (
    .clk(clk), .rst_n(rst_n), .dmem_vaddr(a_vaddr), .dmem_req(a_req), .dmem_write(a_write),
    .dmem_size(a_size), .dmem_wdata(a_wdata), .dmem_byte_en(a_be), .dmem_rdata(a_rdata),
    .dmem_ready(a_ready), .dmem_abort(a_abort)
  );

  arm7tdmi_dmem_responder #(
    .WORD_AW(12), .BASE_ADDR(32'h0), .WAIT_STATES(3), .ALIGN_ABORT(1),
    .WP_BASE(32'h3000), .WP_LIMIT(32'h30FF), .INIT_FILE("")
  ) u_ws3 (
    .clk(clk), .rst_n(rst_n), .dmem_vaddr(b_vaddr), .dmem_req(b_req), .dmem_write(b_write),
    .dmem_size(b_size), .dmem_wdata(b_wdata), .dmem_byte_en(b_be), .dmem_rdata(b_rdata),
    .dmem_ready(b_ready), .dmem_abort(b_abort)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        ab, rdy_after;
  int          lat;

  // Called at posedge+1 with the target idle; returns at posedge+1 one cycle after the response.
  task automatic access(input bit sel, input logic [31:0] addr, input logic wr,
                        input logic [1:0] sz, input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output logic abort, output int latency,
                        output logic ready_after);
    if (sel) begin
      b_vaddr = addr; b_write = wr; b_size = sz; b_wdata = wd; b_be = be; b_req = 1'b1;
    end else begin
      a_vaddr = addr; a_write = wr; a_size = sz; a_wdata = wd; a_be = be; a_req = 1'b1;
    end
    @(posedge clk); #1;
    latency = 1;
    while (((sel ? b_ready : a_ready) !== 1'b1) && latency < 40) begin
      @(posedge clk); #1;
      latency++;
    end
    rdata = sel ? b_rdata : a_rdata;
    abort = sel ? b_abort : a_abort;
    if (sel) b_req = 1'b0; else a_req = 1'b0;
    @(posedge clk); #1;
    ready_after = sel ? b_ready : a_ready;
  endtask

  task automatic test_reset;
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    n_cmp++; if (a_abort !== 1'b0) begin n_err++; $display("FAIL reset_a_abort: got %b want 0", a_abort); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_err++; $display("FAIL reset_a_rdata: got %h want 0", a_rdata); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    n_cmp++; if (b_abort !== 1'b0) begin n_err++; $display("FAIL reset_b_abort: got %b want 0", b_abort); end
    n_cmp++; if (b_rdata !== 32'h0) begin n_err++; $display("FAIL reset_b_rdata: got %h want 0", b_rdata); end
  endtask

  task automatic test_load_ws0;
    access(0, 32'h1000, 1'b1, DSZ_WORD, 32'hDEAD_BEEF, 4'b1111, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0) begin n_err++; $display("FAIL ws0_store_abort: got %b want 0", ab); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ws0_store_rdata_kept: got %h want 0", rd); end
    access(0, 32'h1000, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ws0_latency: got %0d want 1", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ws0_load_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (ab !== 1'b0) begin n_err++; $display("FAIL ws0_load_abort: got %b want 0", ab); end
    n_cmp++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL ws0_ready_one_cycle: got %b want 0", rdy_after); end
  endtask

  task automatic test_byte_lanes;
    access(0, 32'h2004, 1'b1, DSZ_WORD, 32'h0100_0801, 4'b1111, rd, ab, lat, rdy_after);
    access(0, 32'h2004, 1'b1, DSZ_WORD, 32'hCAFE_CAFE, 4'b1100, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0) begin n_err++; $display("FAIL lanes_store_abort: got %b want 0", ab); end
    access(0, 32'h2004, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (rd !== 32'hCAFE_0801) begin n_err++; $display("FAIL lanes_upper_half: got %h want cafe0801", rd); end
    access(0, 32'h2004, 1'b1, DSZ_WORD, 32'hFFFF_FFFF, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0 || lat !== 1) begin n_err++; $display("FAIL lanes_be0_resp: got abort %b lat %0d want 0 1", ab, lat); end
    access(0, 32'h2005, 1'b1, DSZ_BYTE, 32'h7777_7777, 4'b0010, rd, ab, lat, rdy_after);
    access(0, 32'h2004, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (rd !== 32'hCAFE_7701) begin n_err++; $display("FAIL lanes_byte_store: got %h want cafe7701", rd); end
  endtask

  task automatic test_wait_states;
    access(1, 32'h1004, 1'b1, DSZ_WORD, 32'h1234_5678, 4'b1111, rd, ab, lat, rdy_after);
    n_cmp++; if (lat !== 4 || ab !== 1'b0) begin n_err++; $display("FAIL ws3_store: got lat %0d abort %b want 4 0", lat, ab); end
    access(1, 32'h1004, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ws3_latency: got %0d want 4", lat); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL ws3_rdata: got %h want 12345678", rd); end
    n_cmp++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL ws3_ready_one_cycle: got %b want 0", rdy_after); end
  endtask

  task automatic test_back_to_back;
    int pos[$];
    int p0, p1, p2;
    b_vaddr = 32'h1004; b_write = 1'b0; b_size = DSZ_WORD; b_wdata = 32'h0; b_be = 4'b0000;
    b_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (b_ready === 1'b1) pos.push_back(k);
    end
    b_req = 1'b0;
    for (int k = 15; k <= 24; k++) begin
      @(posedge clk); #1;
      if (b_ready === 1'b1) pos.push_back(k);
    end
    p0 = (pos.size() > 0) ? pos[0] : -1;
    p1 = (pos.size() > 1) ? pos[1] : -1;
    p2 = (pos.size() > 2) ? pos[2] : -1;
    n_cmp++; if (pos.size() !== 3) begin n_err++; $display("FAIL b2b_ready_count: got %0d want 3", pos.size()); end
    n_cmp++; if (p0 !== 4 || p1 !== 9 || p2 !== 14) begin n_err++; $display("FAIL b2b_ready_cycles: got %0d %0d %0d want 4 9 14", p0, p1, p2); end
    n_cmp++; if (b_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL b2b_rdata: got %h want 12345678", b_rdata); end
  endtask

  task automatic test_aborts;
    access(0, 32'h1000, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    access(0, 32'h1001, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1 || lat !== 1) begin n_err++; $display("FAIL abort_word_misalign: got abort %b lat %0d want 1 1", ab, lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL abort_rdata_kept: got %h want deadbeef", rd); end
    access(0, 32'h1001, 1'b0, DSZ_HALF, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL abort_half_misalign: got %b want 1", ab); end
    access(0, 32'h1000, 1'b0, DSZ_RSVD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL abort_size_rsvd: got %b want 1", ab); end
    access(0, 32'h4000, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL abort_out_of_window: got %b want 1", ab); end
    n_cmp++; if (rdy_after !== 1'b0 || a_abort !== 1'b0) begin n_err++; $display("FAIL abort_clears: got ready %b abort %b want 0 0", rdy_after, a_abort); end
    access(0, 32'h2006, 1'b0, DSZ_HALF, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0 || rd !== 32'hCAFE_7701) begin n_err++; $display("FAIL half_aligned_load: got abort %b rdata %h want 0 cafe7701", ab, rd); end
    access(0, 32'h0000, 1'b1, DSZ_WORD, 32'hA5A5_A5A5, 4'b1111, rd, ab, lat, rdy_after);
    access(0, 32'h4000, 1'b1, DSZ_WORD, 32'h1111_1111, 4'b1111, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL abort_store_window: got %b want 1", ab); end
    access(0, 32'h0002, 1'b1, DSZ_WORD, 32'h2222_2222, 4'b1111, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL abort_store_misalign: got %b want 1", ab); end
    access(0, 32'h0000, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL abort_no_side_effect: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_write_protect;
    access(0, 32'h3010, 1'b1, DSZ_WORD, 32'hAAAA_AAAA, 4'b1111, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL wp_store_abort: got %b want 1", ab); end
    access(0, 32'h3010, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0) begin n_err++; $display("FAIL wp_load_ok: got %b want 0", ab); end
    n_cmp++; if (rd === 32'hAAAA_AAAA) begin n_err++; $display("FAIL wp_ram_unchanged: got %h want not aaaaaaaa", rd); end
    access(0, 32'h30FF, 1'b1, DSZ_BYTE, 32'hBBBB_BBBB, 4'b1000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b1) begin n_err++; $display("FAIL wp_limit_byte: got %b want 1", ab); end
    access(0, 32'h3100, 1'b1, DSZ_WORD, 32'h5566_7788, 4'b1111, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0) begin n_err++; $display("FAIL wp_above_limit: got %b want 0", ab); end
    access(0, 32'h3100, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (rd !== 32'h5566_7788) begin n_err++; $display("FAIL wp_above_readback: got %h want 55667788", rd); end
    access(0, 32'h2FFC, 1'b1, DSZ_WORD, 32'h99AA_BBCC, 4'b1111, rd, ab, lat, rdy_after);
    access(0, 32'h2FFC, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (ab !== 1'b0 || rd !== 32'h99AA_BBCC) begin n_err++; $display("FAIL wp_below_base: got abort %b rdata %h want 0 99aabbcc", ab, rd); end
  endtask

  task automatic test_reset_mid;
    b_vaddr = 32'h1004; b_write = 1'b1; b_size = DSZ_WORD; b_wdata = 32'h0BAD_F00D; b_be = 4'b1111;
    b_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    n_cmp++; if (b_ready !== 1'b0 || b_abort !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: got ready %b abort %b want 0 0", b_ready, b_abort); end
    n_cmp++; if (b_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_rdata: got %h want 0", b_rdata); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 32'h1004, 1'b0, DSZ_WORD, 32'h0, 4'b0000, rd, ab, lat, rdy_after);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL rst_mid_not_committed: got %h want 12345678", rd); end
    n_cmp++; if (lat !== 4 || ab !== 1'b0) begin n_err++; $display("FAIL rst_mid_next_access: got lat %0d abort %b want 4 0", lat, ab); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_vaddr = '0; a_req = 1'b0; a_write = 1'b0; a_size = 2'b00; a_wdata = '0; a_be = '0;
    b_vaddr = '0; b_req = 1'b0; b_write = 1'b0; b_size = 2'b00; b_wdata = '0; b_be = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_load_ws0();
    test_byte_lanes();
    test_wait_states();
    test_back_to_back();
    test_aborts();
    test_write_protect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
